// File: rtl/dmem_if.sv
// Request/response bundle between the MEM-stage data port and dmem_responder.
// The pipeline side drives the request fields; the responder drives status and read data.
interface dmem_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2:0]            func3;
  logic [DATA_W-1:0]     rd_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output MemRead, MemWrite, addr, wr_data, func3,
    input  rd_data, busy, done, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wr_data, func3,
    output rd_data, busy, done, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory with programmable wait states.
// One access in flight: latch in IDLE, count in WAIT, respond and commit in DONE.
module dmem_responder #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic  clk,
  input logic  reset,
  dmem_if.slave bus
);
  localparam int DEPTH = 1 << DM_ADDRESS;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  store_q, store_d;
  logic                  err_q, err_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            func3_q, func3_d;

  logic [7:0]            mem [DEPTH];
  logic [DM_ADDRESS-1:0] lane_addr [4];
  logic [7:0]            rbyte [4];
  logic [3:0]            lane_we;
  logic [DATA_W-1:0]     load_val;
  logic                  req;
  logic                  commit;

  assign req = bus.MemRead | bus.MemWrite;

  // Dual requests are stores with an error; loads accept 5 sizes, stores 3.
  function automatic logic access_bad(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else begin
      case (f3)
        3'b000:         bad = 1'b0;
        3'b001:         bad = a[0];
        3'b010:         bad = |a;
        3'b100, 3'b101: bad = wr | (f3[0] & a[0]);
        default:        bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    func3_d = func3_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          store_d = bus.MemWrite;
          err_d   = access_bad(bus.MemRead, bus.MemWrite, bus.func3, bus.addr[1:0]);
          addr_d  = bus.addr;
          wdata_d = bus.wr_data;
          func3_d = bus.func3;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte lanes wrap modulo the storage size; aligned accesses never straddle the top.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr_q + DM_ADDRESS'(i);
      rbyte[i]     = mem[lane_addr[i]];
    end
  end

  always_comb begin
    load_val = '0;
    case (func3_q)
      3'b000:  load_val = {{24{rbyte[0][7]}}, rbyte[0]};
      3'b001:  load_val = {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
      3'b010:  load_val = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
      3'b100:  load_val = {24'b0, rbyte[0]};
      3'b101:  load_val = {16'b0, rbyte[1], rbyte[0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    bus.busy    = reset & req & (state_q != ST_DONE);
    bus.done    = (state_q == ST_DONE);
    bus.err     = (state_q == ST_DONE) & err_q;
    bus.rd_data = ((state_q == ST_DONE) && !store_q && !err_q) ? load_val : '0;
  end

  assign commit = (state_q == ST_DONE) && store_q && !err_q;

  always_comb begin
    lane_we = 4'b0000;
    if (commit) begin
      case (func3_q[1:0])
        2'b00:   lane_we = 4'b0001;
        2'b01:   lane_we = 4'b0011;
        default: lane_we = 4'b1111;
      endcase
    end
  end

  // NOTE: storage has no reset; a reset during DONE clears state_q first, so nothing commits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) mem[lane_addr[i]] <= wdata_q[8*i +: 8];
    end
  end
endmodule
